mem_issue_queue: RTL and testbench
==================================

# mem_issue_queue

In-order issue queue for load/store micro-ops, feeding the memory execution stage. It buffers dispatched memory micro-ops and captures missing source operands from result bypass buses. It issues the oldest micro-op once both operands are present, as a registered packet in the memory stage's input format. It also handles branch-mask kill and clear for entries still in flight.

## Interface
- `DEPTH_W`, 3: log2 of queue depth; depth = 2**DEPTH_W = 8.
- `WIDTH_REG`, 5: register tag width.
- `WIDTH_BRM`, 4: branch mask width.
- `WIDTH`, 4*32+WIDTH_REG+WIDTH_BRM+7+10+1: issued packet width (155 at defaults).

Ports:
- `i_clk` in 1: clock; all state changes on the rising edge.
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_en` in 1: enqueue request.
- `i_uop` in 7: opcode (0000011 load, 0100011 store).
- `i_func` in 10: access size code (0 byte, 1 half, 2 word).
- `i_brmask` in WIDTH_BRM: branches this op depends on.
- `i_rd` in WIDTH_REG: destination tag.
- `i_pc` in 32: micro-op PC.
- `i_imm` in 32: address offset.
- `i_rs1`, `i_rs2` in WIDTH_REG: source tags.
- `i_op1`, `i_op2` in 32: source values, valid when the matching ready bit is set.
- `i_rdy1`, `i_rdy2` in 1: source value already present.
- `i_bypass0`, `i_bypass1` in 33+WIDTH_REG: {val, tag, data} result broadcasts.
- `i_brkill` in WIDTH_BRM: mispredicted-branch bits; one-cycle pulse.
- `i_brclr` in WIDTH_BRM: correctly-resolved branch bits; one-cycle pulse.
- `o_instr` out WIDTH: registered packet {val, uop, brmask, rd, pc, func, imm, op2, op1}; val is the MSB.
- `o_full` out 1: count == depth.
- `o_empty` out 1: count == 0.

## Operation
- **Storage and pointers.** Circular FIFO with head/tail pointers of DEPTH_W+1 bits (extra wrap bit).
  - Empty when the pointers are equal.
  - Full when the low bits are equal and the wrap bits differ.
- **Entry contents.** Each entry holds a live bit, all packet fields, rs1/rs2 tags, and rdy1/rdy2.
- **Enqueue.** Accepted when `i_en` && !`o_full` (full evaluated before the edge).
  - When full, the request is dropped silently, even if an issue frees a slot that same cycle.
  - The new entry's brmask is stored as `i_brmask & ~i_brclr`.
  - The entry is not live if `i_brmask & i_brkill` != 0.
- **Wakeup.** For every entry slot and for the incoming op, each source with rdy=0 is checked against both bypasses.
  - On `val` && tag == source tag, the data is captured and rdy is set.
  - `i_bypass0` wins if both buses match.
  - Tag 0 broadcasts are ignored.
- **Issue.** Examined at the head only, strictly in order (loads never pass stores).
  - Head live && rdy1 && rdy2 (registered bits): pop, and load `o_instr` with val=1 and the head fields, with brmask cleared by `i_brclr`.
  - Head not live: pop it and load `o_instr` with all zeros. A killed entry therefore costs one bubble cycle.
  - Head live but not ready, or queue empty: no pop; `o_instr` is all zeros.
- **Branch kill.** Every entry with `brmask & i_brkill` != 0 has its live bit cleared that edge.
  - If the head is issuing that cycle and is hit by `i_brkill`, it is popped with `o_instr` = 0.
- **Branch clear.** `brmask &= ~i_brclr` is applied in all entries.
- **Simultaneous events.** Enqueue and issue in the same cycle are both honoured; the count is unchanged.
- **Pointer wrap.** Depth-1 to 0 wraps naturally and toggles the wrap bit.

## Timing
- **Reset values.** Asynchronous assertion clears pointers, all live/rdy bits, and `o_instr` to 0. `o_full` resets to 0 and `o_empty` to 1. Reset mid-operation discards all contents.
- **Enqueue with ready operands.** An op enqueued at edge N with both rdy set can issue at edge N+1 at the earliest, if it is at the head.
- **Wakeup latency.** A wakeup captured at edge N allows issue at edge N+1; there is no same-cycle bypass-to-issue path.
- **Issue rate.** At most one issue or pop per cycle.
- **Output hold.** `o_instr` is valid for exactly one cycle per issued op; it returns to 0 next cycle unless another op issues.
- **Status outputs.** `o_full` and `o_empty` are combinational from the pointers and reflect state after the last edge.

## Test plan
- **Reset and single load.** Release reset, then enqueue a load with uop=0000011, rdy1=rdy2=1, op1=0x100, imm=4, rd=7.
  - One cycle later, `o_instr` has val=1, op1=0x100, imm=4, rd=7.
  - The cycle after that, `o_instr`=0 and `o_empty`=1.
- **Wakeup.** Enqueue a store with rs1=3, rdy1=0, rdy2=1.
  - Nothing issues while waiting.
  - Drive `i_bypass1`={1,3,0xDEAD}; the store issues one cycle later with op1=0xDEAD.
- **Bypass conflict.** Drive both bypasses with tag 3, data 0x11 on bypass0 and 0x22 on bypass1 → the captured op1 is 0x11.
- **In-order blocking.** Enqueue A (not ready), then B (ready) → nothing issues.
  - Wake A → A issues, then B issues the next cycle.
- **Full and wrap.** Enqueue 9 ops back-to-back, all not ready.
  - `o_full`=1 after 8; the 9th is dropped.
  - Wake all → exactly 8 packets issue in order. Repeat once to exercise pointer wrap.
- **Branch kill and clear.** Enqueue op X with brmask=0010 and op Y with brmask=0100, both not ready.
  - Pulse `i_brkill`=0010 and `i_brclr`=0100, then wake both.
  - X produces a zero bubble; Y issues with brmask=0000.

Source files
------------

// File: rtl/mem_issue_queue.sv
// In-order issue queue for load/store micro-ops.
// Buffers dispatched memory ops, captures missing operands from two result bypass
// buses, and issues the head op as a registered packet once both operands are present.
// Handles branch-mask kill and clear for every entry still in the queue.
module mem_issue_queue #(
    parameter int unsigned DEPTH_W   = 3,
    parameter int unsigned WIDTH_REG = 5,
    parameter int unsigned WIDTH_BRM = 4,
    parameter int unsigned WIDTH     = 4*32 + WIDTH_REG + WIDTH_BRM + 7 + 10 + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic [6:0]            i_uop,
    input  logic [9:0]            i_func,
    input  logic [WIDTH_BRM-1:0]  i_brmask,
    input  logic [WIDTH_REG-1:0]  i_rd,
    input  logic [31:0]           i_pc,
    input  logic [31:0]           i_imm,
    input  logic [WIDTH_REG-1:0]  i_rs1,
    input  logic [WIDTH_REG-1:0]  i_rs2,
    input  logic [31:0]           i_op1,
    input  logic [31:0]           i_op2,
    input  logic                  i_rdy1,
    input  logic                  i_rdy2,
    input  logic [32+WIDTH_REG:0] i_bypass0,
    input  logic [32+WIDTH_REG:0] i_bypass1,
    input  logic [WIDTH_BRM-1:0]  i_brkill,
    input  logic [WIDTH_BRM-1:0]  i_brclr,
    output logic [WIDTH-1:0]      o_instr,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int unsigned DEPTH = 2 ** DEPTH_W;

    typedef struct packed {
        logic                 live;
        logic [6:0]           uop;
        logic [WIDTH_BRM-1:0] brmask;
        logic [WIDTH_REG-1:0] rd;
        logic [31:0]          pc;
        logic [9:0]           func;
        logic [31:0]          imm;
        logic [31:0]          op2;
        logic [31:0]          op1;
        logic [WIDTH_REG-1:0] rs1;
        logic [WIDTH_REG-1:0] rs2;
        logic                 rdy1;
        logic                 rdy2;
    } entry_t;

    entry_t             ent_q [DEPTH];
    entry_t             ent_d [DEPTH];
    entry_t             new_ent;
    entry_t             head_ent;
    logic [DEPTH_W:0]   head_q, head_d;
    logic [DEPTH_W:0]   tail_q, tail_d;
    logic [WIDTH-1:0]   instr_q, instr_d;
    logic [DEPTH_W-1:0] head_idx;
    logic [DEPTH_W-1:0] tail_idx;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               head_ready;
    logic               head_killed;
    logic [32:0]        w1, w2;
    logic [32:0]        nw1, nw2;

    // Returns {rdy, data} for one source after looking at both bypass buses.
    // bypass0 is applied last so it wins when both buses match; tag 0 never wakes.
    function automatic logic [32:0] wake(
        input logic                  rdy,
        input logic [WIDTH_REG-1:0]  tag,
        input logic [31:0]           data,
        input logic [32+WIDTH_REG:0] b0,
        input logic [32+WIDTH_REG:0] b1
    );
        logic [32:0] res;
        res = {rdy, data};
        if (!rdy && tag != '0) begin
            if (b1[32+WIDTH_REG] && b1[31+WIDTH_REG:32] == tag) res = {1'b1, b1[31:0]};
            if (b0[32+WIDTH_REG] && b0[31+WIDTH_REG:32] == tag) res = {1'b1, b0[31:0]};
        end
        return res;
    endfunction

    // Pointer-derived status; the wrap bit separates full from empty.
    always_comb begin
        head_idx = head_q[DEPTH_W-1:0];
        tail_idx = tail_q[DEPTH_W-1:0];
        empty    = (head_q == tail_q);
        full     = (head_q[DEPTH_W] != tail_q[DEPTH_W]) && (head_idx == tail_idx);
    end

    // Build the incoming entry: clear resolved branches, drop it if already killed,
    // and let it catch a broadcast arriving in the same cycle.
    always_comb begin
        nw1 = wake(i_rdy1, i_rs1, i_op1, i_bypass0, i_bypass1);
        nw2 = wake(i_rdy2, i_rs2, i_op2, i_bypass0, i_bypass1);
        new_ent        = '0;
        new_ent.live   = ((i_brmask & i_brkill) == '0);
        new_ent.uop    = i_uop;
        new_ent.brmask = i_brmask & ~i_brclr;
        new_ent.rd     = i_rd;
        new_ent.pc     = i_pc;
        new_ent.func   = i_func;
        new_ent.imm    = i_imm;
        new_ent.rs1    = i_rs1;
        new_ent.rs2    = i_rs2;
        new_ent.rdy1   = nw1[32];
        new_ent.op1    = nw1[31:0];
        new_ent.rdy2   = nw2[32];
        new_ent.op2    = nw2[31:0];
    end

    // Head issue decision uses only registered ready bits, so a wakeup never issues
    // in the cycle it is captured.
    always_comb begin
        head_ent    = ent_q[head_idx];
        head_ready  = !empty && head_ent.live && head_ent.rdy1 && head_ent.rdy2;
        head_killed = ((head_ent.brmask & i_brkill) != '0);
        // A dead head is popped regardless of its operands, costing one bubble.
        pop         = !empty && (!head_ent.live || (head_ent.rdy1 && head_ent.rdy2));
        // Full is sampled before the edge, so a same-cycle pop never frees a slot.
        push        = i_en && !full;
        instr_d     = '0;
        if (head_ready && !head_killed) begin
            instr_d = {1'b1, head_ent.uop, head_ent.brmask & ~i_brclr, head_ent.rd,
                       head_ent.pc, head_ent.func, head_ent.imm, head_ent.op2, head_ent.op1};
        end
        head_d = head_q + {{DEPTH_W{1'b0}}, pop};
        tail_d = tail_q + {{DEPTH_W{1'b0}}, push};
    end

    // Per-slot wakeup, kill and clear; the slot being written takes the new entry.
    always_comb begin
        w1 = '0;
        w2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            w1 = wake(ent_q[i].rdy1, ent_q[i].rs1, ent_q[i].op1, i_bypass0, i_bypass1);
            w2 = wake(ent_q[i].rdy2, ent_q[i].rs2, ent_q[i].op2, i_bypass0, i_bypass1);
            ent_d[i].rdy1 = w1[32];
            ent_d[i].op1  = w1[31:0];
            ent_d[i].rdy2 = w2[32];
            ent_d[i].op2  = w2[31:0];
            if ((ent_q[i].brmask & i_brkill) != '0) ent_d[i].live = 1'b0;
            ent_d[i].brmask = ent_q[i].brmask & ~i_brclr;
        end
        if (push) ent_d[tail_idx] = new_ent;
    end

    // State registers; reset discards every entry and the output packet.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            instr_q <= '0;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            instr_q <= instr_d;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
        end
    end

    assign o_instr = instr_q;
    assign o_full  = full;
    assign o_empty = empty;

endmodule

// File: tb/tb_mem_issue_queue.sv
// Bench for mem_issue_queue: a queue-level reference model stepped once per clock,
// checked against the DUT every cycle, plus hand-computed literal expectations.
module tb_mem_issue_queue;

    localparam int unsigned DW    = 3;
    localparam int unsigned WREG  = 5;
    localparam int unsigned WBRM  = 4;
    localparam int unsigned WIDTH = 4*32 + WREG + WBRM + 7 + 10 + 1;
    localparam int          DEPTH = 8;
    localparam logic [6:0]  LOAD  = 7'b0000011;
    localparam logic [6:0]  STORE = 7'b0100011;

    logic             i_clk;
    logic             i_rst_n;
    logic             i_en;
    logic [6:0]       i_uop;
    logic [9:0]       i_func;
    logic [WBRM-1:0]  i_brmask;
    logic [WREG-1:0]  i_rd;
    logic [31:0]      i_pc;
    logic [31:0]      i_imm;
    logic [WREG-1:0]  i_rs1;
    logic [WREG-1:0]  i_rs2;
    logic [31:0]      i_op1;
    logic [31:0]      i_op2;
    logic             i_rdy1;
    logic             i_rdy2;
    logic [32+WREG:0] i_bypass0;
    logic [32+WREG:0] i_bypass1;
    logic [WBRM-1:0]  i_brkill;
    logic [WBRM-1:0]  i_brclr;
    logic [WIDTH-1:0] o_instr;
    logic             o_full;
    logic             o_empty;

    int n_vec;
    int n_miss;
    int issued;

    typedef struct {
        logic            live;
        logic [6:0]      uop;
        logic [WBRM-1:0] brmask;
        logic [WREG-1:0] rd;
        logic [31:0]     pc;
        logic [9:0]      func;
        logic [31:0]     imm;
        logic [31:0]     op1;
        logic [31:0]     op2;
        logic [WREG-1:0] rs1;
        logic [WREG-1:0] rs2;
        logic            rdy1;
        logic            rdy2;
    } m_ent_t;

    m_ent_t mq[$];

    mem_issue_queue #(
        .DEPTH_W  (DW),
        .WIDTH_REG(WREG),
        .WIDTH_BRM(WBRM),
        .WIDTH    (WIDTH)
    ) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_en     (i_en),
        .i_uop    (i_uop),
        .i_func   (i_func),
        .i_brmask (i_brmask),
        .i_rd     (i_rd),
        .i_pc     (i_pc),
        .i_imm    (i_imm),
        .i_rs1    (i_rs1),
        .i_rs2    (i_rs2),
        .i_op1    (i_op1),
        .i_op2    (i_op2),
        .i_rdy1   (i_rdy1),
        .i_rdy2   (i_rdy2),
        .i_bypass0(i_bypass0),
        .i_bypass1(i_bypass1),
        .i_brkill (i_brkill),
        .i_brclr  (i_brclr),
        .o_instr  (o_instr),
        .o_full   (o_full),
        .o_empty  (o_empty)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Packet field views (val MSB, then uop, brmask, rd, pc, func, imm, op2, op1).
    function automatic logic [63:0] f_val();   return 64'(o_instr[154]);     endfunction
    function automatic logic [63:0] f_uop();   return 64'(o_instr[153:147]); endfunction
    function automatic logic [63:0] f_brm();   return 64'(o_instr[146:143]); endfunction
    function automatic logic [63:0] f_rd();    return 64'(o_instr[142:138]); endfunction
    function automatic logic [63:0] f_pc();    return 64'(o_instr[137:106]); endfunction
    function automatic logic [63:0] f_imm();   return 64'(o_instr[95:64]);   endfunction
    function automatic logic [63:0] f_op1();   return 64'(o_instr[31:0]);    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_pkt(input string name, input logic [WIDTH-1:0] act,
                           input logic [WIDTH-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [32+WREG:0] byp(input logic [WREG-1:0] tag,
                                             input logic [31:0] data);
        return {1'b1, tag, data};
    endfunction

    // Operand value a waiting source holds after this edge; bypass0 has priority.
    function automatic logic [32:0] m_src(input logic rdy, input logic [31:0] v,
                                          input logic [WREG-1:0] tag);
        if (rdy) return {1'b1, v};
        if (tag == 0) return {1'b0, v};
        if (i_bypass0[32+WREG] && i_bypass0[31+WREG:32] == tag) return {1'b1, i_bypass0[31:0]};
        if (i_bypass1[32+WREG] && i_bypass1[31+WREG:32] == tag) return {1'b1, i_bypass1[31:0]};
        return {1'b0, v};
    endfunction

    task automatic idle();
        i_en      = 1'b0;
        i_uop     = '0;
        i_func    = '0;
        i_brmask  = '0;
        i_rd      = '0;
        i_pc      = '0;
        i_imm     = '0;
        i_rs1     = '0;
        i_rs2     = '0;
        i_op1     = '0;
        i_op2     = '0;
        i_rdy1    = 1'b0;
        i_rdy2    = 1'b0;
        i_bypass0 = '0;
        i_bypass1 = '0;
        i_brkill  = '0;
        i_brclr   = '0;
    endtask

    task automatic set_op(input logic [6:0] uop, input logic [WBRM-1:0] brm,
                          input logic [WREG-1:0] rd, input logic [31:0] pc,
                          input logic [31:0] imm, input logic [WREG-1:0] rs1,
                          input logic rdy1, input logic [31:0] op1,
                          input logic [WREG-1:0] rs2, input logic rdy2,
                          input logic [31:0] op2);
        i_en     = 1'b1;
        i_uop    = uop;
        i_func   = 10'd2;
        i_brmask = brm;
        i_rd     = rd;
        i_pc     = pc;
        i_imm    = imm;
        i_rs1    = rs1;
        i_rdy1   = rdy1;
        i_op1    = op1;
        i_rs2    = rs2;
        i_rdy2   = rdy2;
        i_op2    = op2;
    endtask

    // Advance the model by one clock from the current inputs, clock the DUT, compare.
    task automatic step();
        logic [WIDTH-1:0] exp_instr;
        logic             was_full;
        m_ent_t           e;
        logic [32:0]      s;
        exp_instr = '0;
        was_full  = (mq.size() == DEPTH);
        if (mq.size() != 0) begin
            e = mq[0];
            if (!e.live) begin
                mq.delete(0);
            end else if (e.rdy1 && e.rdy2) begin
                if ((e.brmask & i_brkill) == '0)
                    exp_instr = {1'b1, e.uop, e.brmask & ~i_brclr, e.rd, e.pc, e.func,
                                 e.imm, e.op2, e.op1};
                mq.delete(0);
            end
        end
        for (int k = 0; k < mq.size(); k++) begin
            e = mq[k];
            s = m_src(e.rdy1, e.op1, e.rs1);
            e.rdy1 = s[32];
            e.op1  = s[31:0];
            s = m_src(e.rdy2, e.op2, e.rs2);
            e.rdy2 = s[32];
            e.op2  = s[31:0];
            if ((e.brmask & i_brkill) != '0) e.live = 1'b0;
            e.brmask = e.brmask & ~i_brclr;
            mq[k] = e;
        end
        if (i_en && !was_full) begin
            e.live   = ((i_brmask & i_brkill) == '0);
            e.uop    = i_uop;
            e.brmask = i_brmask & ~i_brclr;
            e.rd     = i_rd;
            e.pc     = i_pc;
            e.func   = i_func;
            e.imm    = i_imm;
            e.rs1    = i_rs1;
            e.rs2    = i_rs2;
            s = m_src(i_rdy1, i_op1, i_rs1);
            e.rdy1 = s[32];
            e.op1  = s[31:0];
            s = m_src(i_rdy2, i_op2, i_rs2);
            e.rdy2 = s[32];
            e.op2  = s[31:0];
            mq.push_back(e);
        end
        @(posedge i_clk);
        #1;
        chk_pkt("instr", o_instr, exp_instr);
        chk("full", 64'(o_full), 64'(mq.size() == DEPTH));
        chk("empty", 64'(o_empty), 64'(mq.size() == 0));
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        idle();
        i_rst_n = 1'b1;
        #2 i_rst_n = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_instr", 64'(o_instr == '0), 64'd1);
        chk("rst_empty", 64'(o_empty), 64'd1);
        chk("rst_full", 64'(o_full), 64'd0);
        i_rst_n = 1'b1;

        // Single ready load issues one cycle after enqueue.
        set_op(LOAD, 4'b0, 5'd7, 32'h1000, 32'd4, 5'd1, 1'b1, 32'h100, 5'd2, 1'b1, 32'h0);
        step(); idle();
        step();
        chk("ld_val", f_val(), 64'd1);
        chk("ld_op1", f_op1(), 64'h100);
        chk("ld_imm", f_imm(), 64'd4);
        chk("ld_rd", f_rd(), 64'd7);
        chk("ld_uop", f_uop(), 64'(LOAD));
        step();
        chk("ld_after", 64'(o_instr == '0), 64'd1);
        chk("ld_empty", 64'(o_empty), 64'd1);

        // Store waits on rs1 and wakes from bypass1.
        set_op(STORE, 4'b0, 5'd0, 32'h1004, 32'd8, 5'd3, 1'b0, 32'h0, 5'd2, 1'b1, 32'h55);
        step(); idle();
        step(); chk("st_wait0", f_val(), 64'd0);
        step(); chk("st_wait1", f_val(), 64'd0);
        i_bypass1 = byp(5'd3, 32'hDEAD);
        step(); idle();
        chk("st_wake_edge", f_val(), 64'd0);
        step();
        chk("st_val", f_val(), 64'd1);
        chk("st_op1", f_op1(), 64'hDEAD);
        chk("st_uop", f_uop(), 64'(STORE));

        // Both buses match: bypass0 wins.
        set_op(STORE, 4'b0, 5'd0, 32'h1008, 32'd0, 5'd3, 1'b0, 32'h0, 5'd2, 1'b1, 32'h0);
        step(); idle();
        i_bypass0 = byp(5'd3, 32'h11);
        i_bypass1 = byp(5'd3, 32'h22);
        step(); idle();
        step();
        chk("conflict_op1", f_op1(), 64'h11);

        // Broadcast in the enqueue cycle is captured by the incoming op.
        set_op(LOAD, 4'b0, 5'd9, 32'h100C, 32'd0, 5'd9, 1'b0, 32'h0, 5'd0, 1'b1, 32'h0);
        i_bypass1 = byp(5'd9, 32'h77);
        step(); idle();
        step();
        chk("inwake_val", f_val(), 64'd1);
        chk("inwake_op1", f_op1(), 64'h77);

        // In-order: ready B stays behind waiting A.
        set_op(LOAD, 4'b0, 5'd1, 32'hA0, 32'd0, 5'd4, 1'b0, 32'h0, 5'd0, 1'b1, 32'h0);
        step();
        set_op(LOAD, 4'b0, 5'd2, 32'hB0, 32'd0, 5'd0, 1'b1, 32'h5, 5'd0, 1'b1, 32'h0);
        step(); idle();
        step(); chk("order_block0", f_val(), 64'd0);
        step(); chk("order_block1", f_val(), 64'd0);
        i_bypass0 = byp(5'd4, 32'hAAAA);
        step(); idle();
        step();
        chk("order_a_pc", f_pc(), 64'hA0);
        chk("order_a_op1", f_op1(), 64'hAAAA);
        step();
        chk("order_b_pc", f_pc(), 64'hB0);

        // Enqueue and issue in the same cycle.
        set_op(LOAD, 4'b0, 5'd3, 32'hC0, 32'd0, 5'd0, 1'b1, 32'h1, 5'd0, 1'b1, 32'h2);
        step();
        set_op(LOAD, 4'b0, 5'd4, 32'hC4, 32'd0, 5'd0, 1'b1, 32'h3, 5'd0, 1'b1, 32'h4);
        step(); idle();
        chk("simul_p_pc", f_pc(), 64'hC0);
        chk("simul_not_empty", 64'(o_empty), 64'd0);
        step();
        chk("simul_q_pc", f_pc(), 64'hC4);
        step();
        chk("simul_empty", 64'(o_empty), 64'd1);

        // Fill past full, drain, twice so the pointers wrap.
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 9; k++) begin
                set_op(LOAD, 4'b0, 5'(k), 32'h2000 + 32'(r) * 32'h100 + 32'(k) * 32'd4,
                       32'd0, 5'd6, 1'b0, 32'h0, 5'd0, 1'b1, 32'h0);
                step();
                if (k >= 7) chk("full_flag", 64'(o_full), 64'd1);
            end
            idle();
            i_bypass0 = byp(5'd6, 32'h600 + 32'(r));
            step(); idle();
            issued = 0;
            for (int k = 0; k < 8; k++) begin
                // Request while still full is dropped even though a pop happens.
                if (k == 0)
                    set_op(LOAD, 4'b0, 5'd0, 32'hDEAD0, 32'd0, 5'd0, 1'b1, 32'h0,
                           5'd0, 1'b1, 32'h0);
                step(); idle();
                if (f_val() == 64'd1) issued++;
                chk("drain_pc", f_pc(), 64'h2000 + 64'(r) * 64'h100 + 64'(k) * 64'd4);
                chk("drain_op1", f_op1(), 64'h600 + 64'(r));
            end
            step();
            chk("drain_issued", 64'(issued), 64'd8);
            chk("drain_empty", 64'(o_empty), 64'd1);
        end

        // Kill X, clear Y's branch, then wake both.
        set_op(LOAD, 4'b0010, 5'd3, 32'hE0, 32'd0, 5'd7, 1'b0, 32'h0, 5'd0, 1'b1, 32'h0);
        step();
        set_op(STORE, 4'b0100, 5'd0, 32'hE4, 32'd0, 5'd7, 1'b0, 32'h0, 5'd0, 1'b1, 32'h0);
        step(); idle();
        i_brkill = 4'b0010;
        i_brclr  = 4'b0100;
        step(); idle();
        chk("kill_nothing", f_val(), 64'd0);
        i_bypass0 = byp(5'd7, 32'h70);
        step(); idle();
        chk("kill_bubble", 64'(o_instr == '0), 64'd1);
        chk("kill_y_waiting", 64'(o_empty), 64'd0);
        step();
        chk("clr_y_val", f_val(), 64'd1);
        chk("clr_y_pc", f_pc(), 64'hE4);
        chk("clr_y_brm", f_brm(), 64'd0);

        // Ready head killed as it issues.
        set_op(LOAD, 4'b0001, 5'd0, 32'hF0, 32'd0, 5'd0, 1'b1, 32'h0, 5'd0, 1'b1, 32'h0);
        step(); idle();
        i_brkill = 4'b0001;
        step(); idle();
        chk("kill_issue_zero", 64'(o_instr == '0), 64'd1);
        chk("kill_issue_empty", 64'(o_empty), 64'd1);

        // Branch resolved correctly as the head issues.
        set_op(LOAD, 4'b1000, 5'd5, 32'hF4, 32'd0, 5'd0, 1'b1, 32'h9, 5'd0, 1'b1, 32'h0);
        step(); idle();
        i_brclr = 4'b1010;
        step(); idle();
        chk("clr_issue_val", f_val(), 64'd1);
        chk("clr_issue_brm", f_brm(), 64'd0);

        // Op killed on arrival becomes a bubble.
        set_op(LOAD, 4'b0100, 5'd5, 32'hF8, 32'd0, 5'd0, 1'b1, 32'h9, 5'd0, 1'b1, 32'h0);
        i_brkill = 4'b0100;
        step(); idle();
        step();
        chk("arrive_kill_zero", 64'(o_instr == '0), 64'd1);
        chk("arrive_kill_empty", 64'(o_empty), 64'd1);

        // Tag-0 broadcast wakes nothing; reset mid-operation then clears the queue.
        set_op(LOAD, 4'b0, 5'd0, 32'h1111, 32'd0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b1, 32'h0);
        step(); idle();
        i_bypass0 = {1'b1, 5'd0, 32'h99};
        step(); idle();
        step();
        step();
        chk("tag0_no_issue", f_val(), 64'd0);
        chk("tag0_still_queued", 64'(o_empty), 64'd0);
        i_rst_n = 1'b0;
        #2;
        chk("midrst_empty", 64'(o_empty), 64'd1);
        chk("midrst_full", 64'(o_full), 64'd0);
        chk("midrst_instr", 64'(o_instr == '0), 64'd1);
        mq.delete();
        i_rst_n = 1'b1;
        step();
        set_op(LOAD, 4'b0, 5'd6, 32'h5000, 32'd0, 5'd0, 1'b1, 32'h42, 5'd0, 1'b1, 32'h0);
        step(); idle();
        step();
        chk("post_rst_pc", f_pc(), 64'h5000);
        chk("post_rst_op1", f_op1(), 64'h42);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
